// File: rtl/cam_frame_writer_if.sv
// Write-side bus from cam_frame_writer to the 32-bit frame memory.
// The master drives the write request; the memory slave returns mem_gnt.
interface cam_frame_writer_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              mem_gnt;

    modport master (
        output address, byteenable, chipselect, write, writedata,
        input  mem_gnt
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata,
        output mem_gnt
    );
endinterface

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: packs RGB565 pixel pairs into 32-bit words and writes one frame to memory.
// Define CAM_FRAME_WRITER_OVF_CNT_EN to add the saturating ovf_count output.
module cam_frame_writer #(
    parameter int ADDR_W      = 16,
    parameter int BASE_WORD   = 0,
    parameter int FRAME_WORDS = 38400,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pix_valid,
    input  logic               pix_sof,
    input  logic [15:0]        pix_data,
    cam_frame_writer_if.master mem,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               sync_err
`ifdef CAM_FRAME_WRITER_OVF_CNT_EN
    ,
    output logic [15:0]        ovf_count
`endif
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    localparam int IDX_W = $clog2(FRAME_WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ADDR_W + 32;
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_WORD);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    ONE_CNT  = (PTR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              phase_q, phase_d;
    logic [15:0]       even_q, even_d;
    logic              push_vld_q, push_vld_d;
    logic [ENT_W-1:0]  push_ent_q, push_ent_d;
    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [PTR_W:0]    count_q, count_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       writedata_q, writedata_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              sync_err_q, sync_err_d;
    logic              pop, push_ok;
`ifdef CAM_FRAME_WRITER_OVF_CNT_EN
    logic [15:0]       ovf_cnt_q, ovf_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        even_d      = even_q;
        push_vld_d  = 1'b0;
        push_ent_d  = push_ent_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        write_d     = write_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        sync_err_d  = sync_err_q;
`ifdef CAM_FRAME_WRITER_OVF_CNT_EN
        ovf_cnt_d   = ovf_cnt_q;
`endif
        rd_next = rd_ptr_q + 1'b1;
        pop     = write_q & mem.mem_gnt;
        push_ok = push_vld_q & ((count_q != FULL_CNT) | pop);

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_next;
        count_d = count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};

        // A dropped word still consumed its index, so later addresses stay aligned.
        if (push_vld_q && !push_ok) begin
            overflow_d = 1'b1;
`ifdef CAM_FRAME_WRITER_OVF_CNT_EN
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
`endif
        end

        // The presented word remains the FIFO head until the memory grants it.
        if (pop) begin
            if (count_q > ONE_CNT) begin
                {address_d, writedata_d} = fifo_q[rd_next];
            end else if (push_ok) begin
                {address_d, writedata_d} = push_ent_q;
            end else begin
                write_d = 1'b0;
            end
        end else if (!write_q && (count_q != '0)) begin
            write_d                  = 1'b1;
            {address_d, writedata_d} = fifo_q[rd_ptr_q];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARMED;
                    idx_d      = '0;
                    phase_d    = 1'b0;
                    overflow_d = 1'b0;
                    sync_err_d = 1'b0;
`ifdef CAM_FRAME_WRITER_OVF_CNT_EN
                    ovf_cnt_d  = '0;
`endif
                end
            end
            ARMED: begin
                if (pix_valid && pix_sof) begin
                    state_d = CAPTURE;
                    even_d  = pix_data;
                    phase_d = 1'b1;
                    idx_d   = '0;
                end
            end
            CAPTURE: begin
                if (pix_valid) begin
                    if (pix_sof) begin
                        sync_err_d = 1'b1;
                        idx_d      = '0;
                        even_d     = pix_data;
                        phase_d    = 1'b1;
                    end else if (!phase_q) begin
                        even_d  = pix_data;
                        phase_d = 1'b1;
                    end else begin
                        push_vld_d = 1'b1;
                        push_ent_d = {BASE_A + ADDR_W'(idx_q), pix_data, even_q};
                        phase_d    = 1'b0;
                        idx_d      = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!push_vld_q && (count_q == '0) && !write_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        even_q     <= even_d;
        push_ent_q <= push_ent_d;
        if (push_ok) fifo_q[wr_ptr_q] <= push_ent_q;
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            phase_q     <= 1'b0;
            push_vld_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            write_q     <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef CAM_FRAME_WRITER_OVF_CNT_EN
            ovf_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            push_vld_q  <= push_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            sync_err_q  <= sync_err_d;
`ifdef CAM_FRAME_WRITER_OVF_CNT_EN
            ovf_cnt_q   <= ovf_cnt_d;
`endif
        end
    end

    assign mem.address    = address_q;
    assign mem.writedata  = writedata_q;
    assign mem.write      = write_q;
    assign mem.chipselect = write_q;
    assign mem.byteenable = write_q ? 4'hF : 4'h0;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign overflow       = overflow_q;
    assign sync_err       = sync_err_q;
`ifdef CAM_FRAME_WRITER_OVF_CNT_EN
    assign ovf_count      = ovf_cnt_q;
`endif
endmodule
